// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle sequencer: opcode map (common with the ALU),
// FSM state encodings, NZCV bit positions and the branch-offset sign extension.
package control_unit_pkg;

    localparam logic [3:0] OP_JMP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LSL = 4'h3;
    localparam logic [3:0] OP_LSR = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_MOV = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_BLT = 4'hD;
    localparam logic [3:0] OP_BGT = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch decision from opcode and current NZCV; JMP always taken, non-branch opcodes never.
module branch_cond
    import control_unit_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_BEQ:  taken = flags[FLG_Z];
            OP_BNE:  taken = !flags[FLG_Z];
            OP_BLT:  taken = flags[FLG_N] ^ flags[FLG_V];
            OP_BGT:  taken = !flags[FLG_Z] && !(flags[FLG_N] ^ flags[FLG_V]);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle fetch/decode/execute sequencer: owns PC and NZCV, drives memory port,
// register file and the external combinational ALU.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [3:0]       rf_raddr0,
    output logic [3:0]       rf_raddr1,
    input  logic [WIDTH-1:0] rf_rdata0,
    input  logic [WIDTH-1:0] rf_rdata1,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [3:0]       alu_func,
    output logic [WIDTH-1:0] alu_op0,
    output logic [WIDTH-1:0] alu_op1,
    output logic             alu_flag_en,
    output logic [3:0]       alu_flag_in,
    input  logic [WIDTH-1:0] alu_q,
    input  logic [3:0]       alu_flag_out,
    output logic [WIDTH-1:0] pc,
    output logic [3:0]       flags,
    output logic [2:0]       state
);

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             taken;

    logic [3:0] op, rd, ra, rb;
    logic [7:0] imm8;
    logic       is_alu;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign ra     = ir_q[7:4];
    assign rb     = ir_q[3:0];
    assign imm8   = ir_q[7:0];
    assign is_alu = (op != OP_JMP) && (op <= OP_XOR);

    assign pc          = pc_q;
    assign flags       = flags_q;
    assign state       = state_q;
    assign alu_flag_in = flags_q;

    branch_cond u_branch_cond (
        .op    (op),
        .flags (flags_q),
        .taken (taken)
    );

    // Outputs decode straight from registered state so reset clears them asynchronously.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rf_raddr0   = '0;
        rf_raddr1   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_func    = '0;
        alu_op0     = '0;
        alu_op1     = '0;
        alu_flag_en = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            ST_DECODE: begin
                rf_raddr0 = ra;
                rf_raddr1 = (op == OP_ST) ? rd : rb;
            end
            ST_EXEC: begin
                if (is_alu || op == OP_CMP) begin
                    alu_func    = is_alu ? op : OP_SUB;
                    alu_op0     = a_q;
                    alu_op1     = b_q;
                    alu_flag_en = 1'b1;
                end else begin
                    alu_func = OP_ADD;
                    alu_op0  = pc_q;
                    alu_op1  = sext8(imm8);
                end
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_ST);
                mem_addr  = a_q;
                mem_wdata = b_q;
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = res_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            flags_q <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_FETCH;
                ST_FETCH: if (mem_ack) begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    a_q   <= rf_rdata0;
                    b_q   <= rf_rdata1;
                    res_q <= {8'h00, imm8};
                    if (op == OP_LD || op == OP_ST) state_q <= ST_MEM;
                    else if (op == OP_MOV)          state_q <= ST_WB;
                    else                            state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_q;
                    if (alu_flag_en) flags_q <= alu_flag_out;
                    if (taken)       pc_q    <= alu_q;
                    state_q <= is_alu ? ST_WB : ST_FETCH;
                end
                ST_MEM: if (mem_ack) begin
                    res_q   <= mem_rdata;
                    state_q <= (op == OP_ST) ? ST_FETCH : ST_WB;
                end
                ST_WB:   state_q <= ST_FETCH;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a directed program is loaded, its expected bus
// events are queued, and a negedge monitor compares every observed event in order.
module tb_control_unit;

    logic        clk, rst_n;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rf_raddr0, rf_raddr1, rf_waddr;
    logic [15:0] rf_rdata0, rf_rdata1, rf_wdata;
    logic        rf_we;
    logic [3:0]  alu_func, alu_flag_in, alu_flag_out;
    logic [15:0] alu_op0, alu_op1, alu_q;
    logic        alu_flag_en;
    logic [15:0] pc;
    logic [3:0]  flags;
    logic [2:0]  state;

    control_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_func(alu_func), .alu_op0(alu_op0), .alu_op1(alu_op1), .alu_flag_en(alu_flag_en),
        .alu_flag_in(alu_flag_in), .alu_q(alu_q), .alu_flag_out(alu_flag_out),
        .pc(pc), .flags(flags), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: memory with 3 wait cycles on writes, register file, reference ALU.
    logic [15:0] mem [0:255];
    logic [15:0] rf  [0:15];
    logic [2:0]  wcnt;
    logic        hold_ack;

    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ack   = mem_req && !hold_ack && (wcnt == (mem_we ? 3'd3 : 3'd0));
    assign rf_rdata0 = rf[rf_raddr0];
    assign rf_rdata1 = rf[rf_raddr1];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 3'd0;
        else                     wcnt <= wcnt + 3'd1;
        if (mem_req && mem_we && mem_ack) mem[mem_addr[7:0]] <= mem_wdata;
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    function automatic logic [19:0] alu_model(input logic [3:0] f, input logic [15:0] x, y,
                                              input logic [3:0] fi);
        logic [16:0] r;
        logic c, v;
        r = {1'b0, x};
        c = fi[1];
        v = fi[0];
        case (f)
            4'd1: begin r = {1'b0, x} + {1'b0, y}; c = r[16];
                        v = (x[15] == y[15]) && (r[15] != x[15]); end
            4'd2: begin r = {1'b0, x} - {1'b0, y}; c = (x < y);
                        v = (x[15] != y[15]) && (r[15] != x[15]); end
            4'd3: r = {1'b0, x << y[3:0]};
            4'd4: r = {1'b0, x >> y[3:0]};
            4'd5: r = {1'b0, x & y};
            4'd6: r = {1'b0, x | y};
            4'd7: r = {1'b0, x ^ y};
            default: r = {1'b0, x};
        endcase
        return {r[15], r[15:0] == 16'h0, c, v, r[15:0]};
    endfunction

    assign {alu_flag_out, alu_q} = alu_model(alu_func, alu_op0, alu_op1, alu_flag_in);

    // Scoreboard. kind 0 FETCH{addr, cycles of previous instr, -, flags}
    // 1 ALU{op0, op1, func, flag_en}  2 RFWRITE{waddr, wdata}  3 STORE{addr, wdata, req cycles, stable}
    typedef struct {
        int          kind;
        logic [15:0] a, b, c;
        logic [3:0]  d;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passed = 0;
    int  cyc    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push(input int k, input logic [15:0] a, b, c, input logic [3:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [15:0] a, b, c, input logic [3:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d a=%h b=%h c=%h d=%h with empty queue", k, a, b, c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.a === a && e.b === b && e.c === c && e.d === d) begin
                passed++;
                $display("cyc %0d event kind %0d a=%h b=%h c=%h d=%h ok", cyc, k, a, b, c, d);
            end else
                $display("FAIL event_kind%0d: got kind %0d a=%h b=%h c=%h d=%h expected kind %0d a=%h b=%h c=%h d=%h",
                         e.kind, k, a, b, c, d, e.kind, e.a, e.b, e.c, e.d);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: classifies each sampled cycle into at most one bus event.
    initial begin
        int          last_fetch;
        logic        in_req, stable;
        logic [15:0] sa, sw, rc;
        logic        swe;
        last_fetch = 0; in_req = 0; stable = 1; sa = 0; sw = 0; rc = 0; swe = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_req = 0;
                last_fetch = 0;
            end else begin
                if (mem_req) begin
                    if (!in_req) begin
                        in_req = 1; rc = 16'd1; sa = mem_addr; sw = mem_wdata; swe = mem_we; stable = 1;
                    end else begin
                        rc = rc + 16'd1;
                        if (mem_addr !== sa || mem_wdata !== sw || mem_we !== swe) stable = 0;
                    end
                end else in_req = 0;

                if (mem_req && mem_ack && !mem_we && state == 3'd1) begin
                    observe(0, mem_addr, 16'(cyc - last_fetch), 16'h0, flags);
                    last_fetch = cyc;
                end
                if (state == 3'd3)
                    observe(1, alu_op0, alu_op1, {12'h0, alu_func}, {3'b0, alu_flag_en});
                else
                    check("flag_en_outside_exec", {31'b0, alu_flag_en}, 32'd0);
                if (rf_we)
                    observe(2, {12'h0, rf_waddr}, rf_wdata, 16'h0, 4'h0);
                if (mem_req && mem_ack && mem_we)
                    observe(3, sa, sw, rc, {3'b0, stable});
                if (mem_req && mem_ack) in_req = 0;
            end
        end
    end

    function automatic logic [31:0] or_outputs();
        return {31'b0, |{mem_req, mem_we, mem_addr, mem_wdata, rf_raddr0, rf_raddr1, rf_we,
                         rf_waddr, rf_wdata, alu_func, alu_op0, alu_op1, alu_flag_en,
                         alu_flag_in, pc, flags, state}};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int i = 0; i < 16; i++)  rf[i]  = 16'h0;
        rf[1] = 16'h0003; rf[2] = 16'h0004; rf[5] = 16'hBEEF;
        mem[0]  = 16'h1312;  mem[1]  = 16'hA105;  mem[2]  = 16'hA205;  mem[3]  = 16'hF012;
        mem[4]  = 16'hC003;  mem[5]  = 16'hB002;  mem[7]  = 16'h0004;  mem[8]  = 16'hD0FE;
        mem[9]  = 16'hF001;  mem[10] = 16'h00FD;  mem[12] = 16'hA140;  mem[13] = 16'h9510;
        mem[14] = 16'h8610;  mem[15] = 16'hA7FF;  mem[16] = 16'h00FF;

        push(0, 16'd0,  16'd1, 0, 4'b0000);
        push(1, 16'd3,  16'd4, 16'd1, 4'd1);          // ADD R3 = R1 + R2
        push(2, 16'd3,  16'd7, 0, 0);
        push(0, 16'd1,  16'd4, 0, 4'b0000);
        push(2, 16'd1,  16'd5, 0, 0);                 // MOV R1, 5
        push(0, 16'd2,  16'd3, 0, 4'b0000);
        push(2, 16'd2,  16'd5, 0, 0);                 // MOV R2, 5
        push(0, 16'd3,  16'd3, 0, 4'b0000);
        push(1, 16'd5,  16'd5, 16'd2, 4'd1);          // CMP R1, R2
        push(0, 16'd4,  16'd3, 0, 4'b0100);
        push(1, 16'd5,  16'd3, 16'd1, 4'd0);          // BNE not taken
        push(0, 16'd5,  16'd3, 0, 4'b0100);
        push(1, 16'd6,  16'd2, 16'd1, 4'd0);          // BEQ taken to 8
        push(0, 16'd8,  16'd3, 0, 4'b0100);
        push(1, 16'd9,  16'hFFFE, 16'd1, 4'd0);       // BLT with N=V=0: not taken
        push(0, 16'd9,  16'd3, 0, 4'b0100);
        push(1, 16'd0,  16'd5, 16'd2, 4'd1);          // CMP R0, R1 -> N=1 C=1
        push(0, 16'd10, 16'd3, 0, 4'b1010);
        push(1, 16'd11, 16'hFFFD, 16'd1, 4'd0);       // JMP -3 to 8
        push(0, 16'd8,  16'd3, 0, 4'b1010);
        push(1, 16'd9,  16'hFFFE, 16'd1, 4'd0);       // BLT taken to 7
        push(0, 16'd7,  16'd3, 0, 4'b1010);
        push(1, 16'd8,  16'd4, 16'd1, 4'd0);          // JMP +4 to 12
        push(0, 16'd12, 16'd3, 0, 4'b1010);
        push(2, 16'd1,  16'h0040, 0, 0);              // MOV R1, 0x40
        push(0, 16'd13, 16'd3, 0, 4'b1010);
        push(3, 16'h0040, 16'hBEEF, 16'd4, 4'd1);     // ST with 3 wait cycles
        push(0, 16'd14, 16'd6, 0, 4'b1010);
        push(2, 16'd6,  16'hBEEF, 0, 0);              // LD R6
        push(0, 16'd15, 16'd4, 0, 4'b1010);
        push(2, 16'd7,  16'h00FF, 0, 0);              // MOV R7, 0xFF
        push(0, 16'd16, 16'd3, 0, 4'b1010);
        push(1, 16'd17, 16'hFFFF, 16'd1, 4'd0);       // JMP -1 self loop
        push(0, 16'd16, 16'd3, 0, 4'b1010);

        // Reset behaviour with a fetch left pending.
        hold_ack = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs_zero", or_outputs(), 32'd0);
        rst_n = 1'b1;
        #1 check("idle_no_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        check("first_fetch_req", {31'b0, mem_req}, 32'd1);
        check("first_fetch_addr", {16'b0, mem_addr}, 32'd0);
        check("state_fetch", {29'b0, state}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_drops_req", {31'b0, mem_req}, 32'd0);
        check("async_reset_outputs_zero", or_outputs(), 32'd0);
        repeat (2) @(negedge clk);
        hold_ack = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) check("timeout_queue_drain", exp_q.size(), 32'd0);
        check("r6_loaded", {16'b0, rf[6]}, 32'h0000BEEF);
        check("mem_0x40_stored", {16'b0, mem[8'h40]}, 32'h0000BEEF);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
